module_calc_entry_mul: RTL and testbench

MODULE_CALC_ENTRY_MUL -- requirements
Module: module_calc_entry_mul

---
 rtl/module_calc_entry_mul.sv | 182 ++++++++++++++++++
 tb/tb_module_calc_entry_mul.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/module_calc_entry_mul.sv
// Keypad calculator front end: enter two BCD operands, multiply them by shift-add, show the product.
// Latency: digit/enter visible next cycle; product + done pulse AW+1 cycles after the second enter.
// Backpressure: none; key strobes arriving while the multiply iterates are dropped.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   key_valid  one-cycle strobe of a debounced key press
//   key_code   hex key code, sampled with key_valid
//   a_bcd      operand A in BCD, newest digit in [3:0]
//   b_bcd      operand B in BCD, same layout
//   product    binary A*B, valid from the done pulse onward
//   phase      00 A entry, 01 B entry, 10 multiply, 11 show result
//   busy       high while the multiply iterates
//   done       one-cycle pulse when product becomes valid
//
// Optional build macro KEYPAD_CLEAR_EN enables the clear key (KEY_CLEAR).
module module_calc_entry_mul #(
    parameter int          NDIG      = 3,
    parameter logic [3:0]  KEY_ENTER = 4'hA,
    parameter logic [3:0]  KEY_CLEAR = 4'hC,
    localparam int         AW        = $clog2(10 ** NDIG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*NDIG-1:0]   a_bcd,
    output logic [4*NDIG-1:0]   b_bcd,
    output logic [2*AW-1:0]     product,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                done
);

    localparam int BW = 4 * NDIG;
    localparam int PW = 2 * AW;
    localparam int CW = $clog2(NDIG + 1);
    localparam int IW = $clog2(AW);

    typedef enum logic [1:0] {
        ENT_A = 2'b00,
        ENT_B = 2'b01,
        MULT  = 2'b10,
        SHOW  = 2'b11
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   a_bin, b_bin;
    logic [CW-1:0]   a_cnt, b_cnt;
    logic [PW-1:0]   mcand;
    logic [AW-1:0]   mplier;
    logic [IW-1:0]   iter;
    logic            is_digit, is_enter, last_iter;

    // The clear code is never a digit, even in builds without the clear
    // feature, so KEY_CLEAR remapped onto 0..9 is simply ignored.
    assign is_digit  = key_valid && (key_code <= 4'd9) && (key_code != KEY_CLEAR);
    assign is_enter  = key_valid && (key_code == KEY_ENTER);
    assign last_iter = (iter == IW'(AW - 1));
    assign phase     = state;

`ifdef KEYPAD_CLEAR_EN
    logic is_clear;
    assign is_clear = key_valid && (key_code == KEY_CLEAR);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ENT_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ENT_A: if (is_enter) state_nxt = ENT_B;
            ENT_B: if (is_enter) state_nxt = MULT;
            MULT: begin
                busy = 1'b1;
                if (last_iter) state_nxt = SHOW;
            end
            SHOW: begin
                if (is_digit) state_nxt = ENT_A;
`ifdef KEYPAD_CLEAR_EN
                else if (is_clear) state_nxt = ENT_A;
`endif
            end
            default: state_nxt = ENT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_bcd   <= '0;
            b_bcd   <= '0;
            a_bin   <= '0;
            b_bin   <= '0;
            a_cnt   <= '0;
            b_cnt   <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            iter    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ENT_A: begin
                    if (is_digit && (a_cnt < CW'(NDIG))) begin
                        a_bcd <= (a_bcd << 4) | BW'(key_code);
                        a_bin <= a_bin * AW'(10) + AW'(key_code);
                        a_cnt <= a_cnt + CW'(1);
                    end
`ifdef KEYPAD_CLEAR_EN
                    else if (is_clear) begin
                        a_bcd <= '0;
                        a_bin <= '0;
                        a_cnt <= '0;
                    end
`endif
                end
                ENT_B: begin
                    if (is_enter) begin
                        // Operands are loaded into private shift registers so
                        // the entry shadows stay intact while iterating.
                        mcand   <= PW'(a_bin);
                        mplier  <= b_bin;
                        iter    <= '0;
                        product <= '0;
                    end else if (is_digit && (b_cnt < CW'(NDIG))) begin
                        b_bcd <= (b_bcd << 4) | BW'(key_code);
                        b_bin <= b_bin * AW'(10) + AW'(key_code);
                        b_cnt <= b_cnt + CW'(1);
                    end
`ifdef KEYPAD_CLEAR_EN
                    else if (is_clear) begin
                        b_bcd <= '0;
                        b_bin <= '0;
                        b_cnt <= '0;
                    end
`endif
                end
                MULT: begin
                    // product doubles as the accumulator; one multiplier bit per cycle.
                    product <= product + (mplier[0] ? mcand : '0);
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    iter    <= iter + IW'(1);
                    if (last_iter) done <= 1'b1;
                end
                SHOW: begin
                    if (is_digit) begin
                        a_bcd   <= BW'(key_code);
                        a_bin   <= AW'(key_code);
                        a_cnt   <= CW'(1);
                        b_bcd   <= '0;
                        b_bin   <= '0;
                        b_cnt   <= '0;
                        product <= '0;
                    end
`ifdef KEYPAD_CLEAR_EN
                    else if (is_clear) begin
                        a_bcd   <= '0;
                        a_bin   <= '0;
                        a_cnt   <= '0;
                        b_bcd   <= '0;
                        b_bin   <= '0;
                        b_cnt   <= '0;
                        product <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_calc_entry_mul.sv
// Bench for module_calc_entry_mul: directed key scenarios plus random key streams
// checked against a decimal-arithmetic model of the calculator.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_module_calc_entry_mul;

    localparam int NDIG = 3;
    localparam int AW   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] a_bcd, b_bcd;
    logic [19:0] product;
    logic [1:0]  phase;
    logic        busy, done;

    always #5 clk = ~clk;

    module_calc_entry_mul dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .product   (product),
        .phase     (phase),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    // Model: operands as plain integers, mode 0..3 = A entry, B entry, multiply, show.
    int m_mode, m_a, m_acnt, m_b, m_bcnt, m_prod;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_prod = 0;
    endtask

    task automatic model_key(input logic [3:0] c);
        case (m_mode)
            0, 1: begin
                if (c == 4'hA) begin
                    m_mode++;
                    if (m_mode == 2) m_prod = m_a * m_b;
                end else if (c <= 4'd9) begin
                    if (m_mode == 0 && m_acnt < NDIG) begin m_a = m_a * 10 + int'(c); m_acnt++; end
                    if (m_mode == 1 && m_bcnt < NDIG) begin m_b = m_b * 10 + int'(c); m_bcnt++; end
                end
`ifdef KEYPAD_CLEAR_EN
                else if (c == 4'hC) begin
                    if (m_mode == 0) begin m_a = 0; m_acnt = 0; end
                    else begin m_b = 0; m_bcnt = 0; end
                end
`endif
            end
            3: begin
                if (c <= 4'd9) begin
                    model_reset();
                    m_a = int'(c); m_acnt = 1;
                end
`ifdef KEYPAD_CLEAR_EN
                else if (c == 4'hC) model_reset();
`endif
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag, input logic exp_done);
        chk({tag, "_a_bcd"}, a_bcd, to_bcd(m_a));
        chk({tag, "_b_bcd"}, b_bcd, to_bcd(m_b));
        chk({tag, "_phase"}, phase, m_mode);
        chk({tag, "_busy"}, busy, m_mode == 2);
        chk({tag, "_done"}, done, exp_done);
        if (m_mode != 2) chk({tag, "_product"}, product, m_prod);
    endtask

    // Called on the first multiply cycle; optionally injects keys 7 and enter mid-multiply.
    task automatic wait_mult(input bit disturb);
        int busy_cnt = 0;
        int done_at  = -1;
        for (int i = 0; i < 64; i++) begin
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            key_valid = disturb && (i == 2 || i == 4);
            key_code  = (i == 2) ? 4'h7 : 4'hA;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("mult_busy_cycles", busy_cnt, AW);
        chk("mult_done_latency", done_at, AW);
        m_mode = 3;
        check_outputs("show", 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("show_product_held", product, m_prod);
    endtask

    task automatic press(input logic [3:0] c, input bit disturb);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        model_key(c);
        check_outputs("key", 1'b0);
        if (m_mode == 2) wait_mult(disturb);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs("reset", 1'b0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        logic [3:0] c;
        int p;

        do_reset();

        // 123 * 45
        press(4'h1, 0); press(4'h2, 0); press(4'h3, 0); press(4'hA, 0);
        press(4'h4, 0); press(4'h5, 0); press(4'hA, 0);
        chk("r026_product", product, 20'd5535);
        chk("r026_a_bcd", a_bcd, 12'h123);
        chk("r026_b_bcd", b_bcd, 12'h045);
        chk("r026_phase", phase, 2'b11);

        // fourth digit ignored, maximum operands
        do_reset();
        press(4'h9, 0); press(4'h9, 0); press(4'h9, 0); press(4'h9, 0); press(4'hA, 0);
        press(4'h9, 0); press(4'h9, 0); press(4'h9, 0); press(4'hA, 0);
        chk("r027_a_bcd", a_bcd, 12'h999);
        chk("r027_product", product, 20'd998001);

        // empty operands commit as zero
        do_reset();
        press(4'hA, 0); press(4'hA, 0);
        chk("r028_product", product, 20'd0);

        // keys during multiply ignored, then a digit restarts entry
        do_reset();
        press(4'h2, 0); press(4'hA, 0); press(4'h3, 0); press(4'hA, 1);
        chk("r029_product", product, 20'd6);
        press(4'h7, 0);
        chk("r029_a_bcd", a_bcd, 12'h007);
        chk("r029_b_bcd", b_bcd, 12'h000);
        chk("r029_phase", phase, 2'b00);

        // reset on the fifth multiply cycle
        do_reset();
        press(4'h1, 0); press(4'h2, 0); press(4'hA, 0); press(4'h3, 0);
        key_valid = 1'b1; key_code = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        chk("r030_busy_first", busy, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("r030", 1'b0);
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
        end
        chk("r030_no_done", seen_done, 0);
        chk("r030_phase_after", phase, 2'b00);

        // clear key behaviour depends on build
        do_reset();
        press(4'h5, 0); press(4'h6, 0); press(4'hC, 0); press(4'h8, 0);
`ifdef KEYPAD_CLEAR_EN
        chk("r031_a_bcd", a_bcd, 12'h008);
`else
        chk("r031_a_bcd", a_bcd, 12'h568);
`endif

        // random key streams
        do_reset();
        for (int n = 0; n < 400; n++) begin
            p = $urandom_range(0, 9);
            if (p < 6)      c = 4'($urandom_range(0, 9));
            else if (p < 8) c = 4'hA;
            else            c = 4'($urandom_range(11, 15));
            press(c, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
